// File: rtl/hd_program_loader_pkg.sv
// Shared definitions for the HD program loader and the instruction memory.
//   loader_state_t : loader FSM state encoding
//   WR_NONE/WR_CODE: imem_wctrl codes (no write / write one word)
//   HD_WORD_W      : width of one HD data word
//   HD_TIMEOUT     : default per-word wait limit for hd_ack
package hd_program_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_REQ   = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } loader_state_t;

  localparam logic [2:0]  WR_NONE    = 3'b000;
  localparam logic [2:0]  WR_CODE    = 3'b001;

  localparam int unsigned HD_WORD_W  = 32;
  localparam int unsigned HD_TIMEOUT = 255;

endpackage

// File: rtl/hd_program_loader_timeout.sv
// Per-word hd_ack watchdog for the program loader.
//   clock, reset : system clock, asynchronous active-high reset
//   clear        : restart the count (ack seen, or not waiting)
//   enable       : one waiting cycle elapsed
//   expired      : this enabled cycle is the LIMIT-th consecutive wait cycle
module hd_timeout_counter #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

  // count holds the number of waiting cycles already completed, so the
  // LIMIT-th waiting cycle is the one where count == LIMIT-1.
  assign expired = enable && (count == W'(LIMIT - 1));

endmodule

// File: rtl/hd_program_loader.sv
// Copies a program image from the HD word interface into instruction memory,
// one 32-bit word per HD handshake, then requests exit from BIOS mode.
//   clock, reset         : system clock, asynchronous active-high reset
//   start                : begin a transfer (accepted only when idle)
//   hd_base, dest_base,
//   word_count           : transfer description, sampled on an accepted start
//   hd_req, hd_addr      : HD read request / word address (held until hd_ack)
//   hd_ack, hd_rdata     : HD read completion with data in the same cycle
//   imem_waddr/wdata/wctrl: instruction-memory write port (wctrl = WR_CODE for one cycle)
//   busy                 : transfer in progress (through the DONE cycle)
//   done                 : one-cycle end-of-transfer pulse
//   error                : sticky failure flag, cleared on the next accepted start
//   end_bios             : one-cycle pulse with done on a successful transfer
module hd_program_loader #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned IMEM_DEPTH = 201,
  parameter logic [2:0]  WR_CODE    = hd_program_loader_pkg::WR_CODE,
  parameter int unsigned TIMEOUT    = hd_program_loader_pkg::HD_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] hd_base,
  input  logic [ADDR_W-1:0] dest_base,
  input  logic [ADDR_W-1:0] word_count,
  output logic              hd_req,
  output logic [ADDR_W-1:0] hd_addr,
  input  logic              hd_ack,
  input  logic [31:0]       hd_rdata,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic [2:0]        imem_wctrl,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              end_bios
);

  import hd_program_loader_pkg::*;

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(IMEM_DEPTH);

  loader_state_t     state, state_next;
  logic [ADDR_W-1:0] hd_base_q, dest_q, count_q;
  logic [ADDR_W-1:0] idx, idx_next;
  logic              err_set, error_next;
  logic              expired;
  logic [ADDR_W:0]   span;

  // One extra bit so that dest_base+word_count wrapping past 2^ADDR_W is
  // treated as out of range rather than as a small end address.
  assign span = {1'b0, dest_q} + {1'b0, count_q};

  hd_timeout_counter #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   ((state != ST_REQ) || hd_ack),
    .enable  (state == ST_REQ),
    .expired (expired)
  );

  always_comb begin
    state_next = state;
    idx_next   = idx;
    err_set    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_CHECK;
      end
      ST_CHECK: begin
        idx_next = '0;
        if (count_q == '0) begin
          state_next = ST_DONE;
        end else if (span > DEPTH_X) begin
          err_set    = 1'b1;
          state_next = ST_DONE;
        end else begin
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (hd_ack) begin
          state_next = ST_WRITE;
        end else if (expired) begin
          err_set    = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_WRITE: begin
        idx_next   = idx + ADDR_W'(1);
        state_next = (idx_next == count_q) ? ST_DONE : ST_REQ;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    error_next = error;
    if (state == ST_IDLE && start) begin
      error_next = 1'b0;
    end else if (err_set) begin
      error_next = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      hd_base_q <= '0;
      dest_q    <= '0;
      count_q   <= '0;
      error     <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      error <= error_next;
      if (state == ST_IDLE && start) begin
        hd_base_q <= hd_base;
        dest_q    <= dest_base;
        count_q   <= word_count;
      end
    end
  end

  // Outputs are registered from the next state, so they line up with the
  // state they belong to instead of lagging it by a cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hd_req     <= 1'b0;
      hd_addr    <= '0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      imem_wctrl <= WR_NONE;
      done       <= 1'b0;
      end_bios   <= 1'b0;
    end else begin
      hd_req     <= (state_next == ST_REQ);
      imem_wctrl <= (state_next == ST_WRITE) ? WR_CODE : WR_NONE;
      done       <= (state_next == ST_DONE);
      end_bios   <= (state_next == ST_DONE) && !error_next;
      if (state_next == ST_REQ) begin
        hd_addr <= hd_base_q + idx_next;
      end
      if (state == ST_REQ && hd_ack) begin
        imem_wdata <= hd_rdata;
        imem_waddr <= dest_q + idx;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_hd_program_loader.sv
// Self-checking bench for hd_program_loader: a table of transfers with
// hand-computed results, plus directed sequences for stray starts/acks and
// reset in the middle of a transfer.
module tb_hd_program_loader;

  localparam logic [2:0] WR = 3'b001;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] hd_base, dest_base, word_count;
  logic        hd_req;
  logic [31:0] hd_addr;
  logic        hd_ack;
  logic [31:0] hd_rdata;
  logic [31:0] imem_waddr, imem_wdata;
  logic [2:0]  imem_wctrl;
  logic        busy, done, error, end_bios;

  hd_program_loader #(
    .ADDR_W     (32),
    .IMEM_DEPTH (201),
    .WR_CODE    (3'b001),
    .TIMEOUT    (255)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .hd_base    (hd_base),
    .dest_base  (dest_base),
    .word_count (word_count),
    .hd_req     (hd_req),
    .hd_addr    (hd_addr),
    .hd_ack     (hd_ack),
    .hd_rdata   (hd_rdata),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .imem_wctrl (imem_wctrl),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .end_bios   (end_bios)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [31:0] hd_base;
    logic [31:0] dest_base;
    logic [31:0] word_count;
    bit          stall_en;
    int unsigned stall_idx;
    int unsigned exp_writes;
    bit          exp_err;
    bit          exp_eb;
    int unsigned exp_lat;
    int unsigned exp_reqs;
  } vec_t;

  vec_t        vecs[8];
  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  int unsigned req_cycles = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [2:0]  wr_ctrl_q[$];

  // HD model: answers one cycle after it first sees a request, so a word
  // costs REQ, REQ+ack, WRITE.  One address can be made to never answer.
  logic        stall_en   = 1'b0;
  logic [31:0] stall_addr = '0;
  logic        force_ack  = 1'b0;
  logic        seen;

  initial begin
    hd_ack   = 1'b0;
    hd_rdata = '0;
    seen     = 1'b0;
    forever begin
      @(negedge clock);
      if (force_ack) begin
        hd_ack   = 1'b1;
        hd_rdata = 32'hDEAD_BEEF;
      end else if (hd_req && seen && !hd_ack && !(stall_en && hd_addr == stall_addr)) begin
        hd_ack   = 1'b1;
        hd_rdata = 32'hC0DE_0000 + hd_addr;
      end else begin
        hd_ack = 1'b0;
      end
      seen = hd_req;
    end
  end

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (imem_wctrl != 3'b000) begin
      wr_addr_q.push_back(imem_waddr);
      wr_data_q.push_back(imem_wdata);
      wr_ctrl_q.push_back(imem_wctrl);
    end
    if (hd_req) req_cycles++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctl"}, {26'd0, hd_req, imem_wctrl, done, end_bios, busy, error}, 32'd0);
    check({tag, "_hd_addr"}, hd_addr, 32'd0);
    check({tag, "_waddr"}, imem_waddr, 32'd0);
    check({tag, "_wdata"}, imem_wdata, 32'd0);
  endtask

  task automatic run_vec(input string tag, input vec_t v, input bit noise);
    int unsigned t0;
    int unsigned lat;
    int          k;
    int          n;
    bit          got;
    logic        eb, er;
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_ctrl_q.delete();
    req_cycles = 0;
    stall_en   = v.stall_en;
    stall_addr = v.hd_base + 32'(v.stall_idx);
    @(negedge clock);
    hd_base    = v.hd_base;
    dest_base  = v.dest_base;
    word_count = v.word_count;
    start      = 1'b1;
    @(negedge clock);
    start = 1'b0;
    if (noise) begin
      hd_base    = 32'h0000_5555;
      dest_base  = '0;
      word_count = 32'd7;
    end
    t0 = cyc;
    check({tag, "_busy_after_start"}, {31'd0, busy}, 32'd1);
    got = 1'b0;
    k   = 0;
    lat = 0;
    eb  = 1'b0;
    er  = 1'b0;
    while (!got && k < 600) begin
      if (done) begin
        got = 1'b1;
        lat = cyc - t0;
        eb  = end_bios;
        er  = error;
      end else begin
        start = noise && (k % 2 == 0);
        @(negedge clock);
        k++;
      end
    end
    check({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    check({tag, "_latency"}, lat, v.exp_lat);
    check({tag, "_end_bios"}, {31'd0, eb}, {31'd0, v.exp_eb});
    check({tag, "_error"}, {31'd0, er}, {31'd0, v.exp_err});
    // a start coinciding with DONE must be dropped
    start = noise;
    @(negedge clock);
    start = 1'b0;
    check({tag, "_done_pulse"}, {30'd0, done, end_bios}, 32'd0);
    check({tag, "_busy_clear"}, {31'd0, busy}, 32'd0);
    @(negedge clock);
    check({tag, "_still_idle"}, {30'd0, busy, hd_req}, 32'd0);
    check({tag, "_error_sticky"}, {31'd0, error}, {31'd0, v.exp_err});
    check({tag, "_writes"}, wr_addr_q.size(), v.exp_writes);
    check({tag, "_hd_req_cycles"}, req_cycles, v.exp_reqs);
    n = (wr_addr_q.size() < int'(v.exp_writes)) ? wr_addr_q.size() : int'(v.exp_writes);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_waddr%0d", tag, i), wr_addr_q[i], v.dest_base + 32'(i));
      check($sformatf("%s_wdata%0d", tag, i), wr_data_q[i], 32'hC0DE_0000 + (v.hd_base + 32'(i)));
      check($sformatf("%s_wctrl%0d", tag, i), {29'd0, wr_ctrl_q[i]}, {29'd0, WR});
    end
    stall_en = 1'b0;
  endtask

  initial begin
    //          hd_base       dest_base     count  stall idx  wr err eb lat  reqs
    vecs[0] = '{32'd10,       32'd0,        32'd4, 1'b0, 0,   4, 0, 1, 13,  8};
    vecs[1] = '{32'd5,        32'd7,        32'd0, 1'b0, 0,   0, 0, 1, 1,   0};
    vecs[2] = '{32'd0,        32'd198,      32'd5, 1'b0, 0,   0, 1, 0, 1,   0};
    vecs[3] = '{32'd300,      32'd196,      32'd5, 1'b0, 0,   5, 0, 1, 16,  10};
    vecs[4] = '{32'd0,        32'hFFFF_FFFF,32'd2, 1'b0, 0,   0, 1, 0, 1,   0};
    vecs[5] = '{32'hFFFF_FFFE,32'd50,       32'd3, 1'b0, 0,   3, 0, 1, 10,  6};
    vecs[6] = '{32'd100,      32'd20,       32'd4, 1'b1, 2,   2, 1, 0, 262, 259};
    vecs[7] = '{32'd7,        32'd200,      32'd1, 1'b0, 0,   1, 0, 1, 4,   2};

    reset      = 1'b1;
    start      = 1'b0;
    hd_base    = '0;
    dest_base  = '0;
    word_count = '0;
    repeat (3) @(negedge clock);
    check_idle_outputs("reset_held");
    reset = 1'b0;
    @(negedge clock);
    check_idle_outputs("after_reset");

    for (int i = 0; i < 8; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i], 1'b0);
    end

    // Stray ack while idle, then stray starts throughout a transfer.
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_ctrl_q.delete();
    @(posedge clock);
    #1 force_ack = 1'b1;
    @(posedge clock);
    #1 force_ack = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("idle_ack_ctl", {28'd0, busy, hd_req, done, error}, 32'd0);
    check("idle_ack_writes", wr_addr_q.size(), 32'd0);
    run_vec("noise", '{32'd40, 32'd60, 32'd3, 1'b0, 0, 3, 0, 1, 10, 6}, 1'b1);

    // Reset during the WRITE of the last word, then a clean rerun.
    begin
      bit found;
      found = 1'b0;
      @(negedge clock);
      hd_base    = 32'd10;
      dest_base  = 32'd0;
      word_count = 32'd4;
      start      = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int k = 0; k < 50 && !found; k++) begin
        @(negedge clock);
        if (imem_wctrl != 3'b000 && imem_waddr == 32'd3) found = 1'b1;
      end
      check("rst_reached_write3", {31'd0, found}, 32'd1);
      #1 reset = 1'b1;
      #1 check_idle_outputs("rst_mid");
      @(negedge clock);
      check_idle_outputs("rst_mid_held");
      reset = 1'b0;
      @(negedge clock);
      check_idle_outputs("rst_mid_release");
      run_vec("rerun", vecs[0], 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
